// File: rtl/aes_uart_byte_serializer_if.sv
// rtl/aes_uart_byte_serializer_if.sv - block handshake and UART transmitter signals
interface aes_uart_byte_serializer_if #(
  parameter int NUM_BYTES = 16
);
  logic                   blk_valid;
  logic [8*NUM_BYTES-1:0] blk_data;
  logic                   blk_ready;
  logic                   tx_trigger;
  logic [7:0]             tx_data;
  logic                   tx_busy;

  modport master (
    output blk_valid, blk_data, tx_busy,
    input  blk_ready, tx_trigger, tx_data
  );

  modport slave (
    input  blk_valid, blk_data, tx_busy,
    output blk_ready, tx_trigger, tx_data
  );
endinterface

// File: rtl/aes_uart_byte_serializer.sv
// rtl/aes_uart_byte_serializer.sv - splits a 128-bit AES block into bytes for the UART transmitter
module aes_uart_byte_serializer #(
  parameter int NUM_BYTES   = 16,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  aes_uart_byte_serializer_if.slave    bus,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(NUM_BYTES)-1:0] byte_idx
);

  localparam int W     = 8 * NUM_BYTES;
  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam int CNT_W = $clog2(ACK_TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SEND      = 2'd1;
  localparam logic [1:0] S_WAIT_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]       state;
  logic [W-1:0]     sr;
  logic [W-1:0]     sr_next;
  logic [7:0]       tx_data_q;
  logic [7:0]       in_head;
  logic [7:0]       next_head;
  logic [CNT_W-1:0] cnt;

  // Head of the shift register sits at the top for MSB-first, at the bottom otherwise.
  always_comb begin
    if (MSB_FIRST) begin
      sr_next   = sr << 8;
      in_head   = bus.blk_data[W-1 -: 8];
      next_head = sr[W-9 -: 8];
    end else begin
      sr_next   = sr >> 8;
      in_head   = bus.blk_data[7:0];
      next_head = sr[15:8];
    end
  end

  assign bus.blk_ready  = (state == S_IDLE);
  assign bus.tx_trigger = (state == S_SEND) && !bus.tx_busy;
  assign bus.tx_data    = tx_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sr        <= '0;
      tx_data_q <= '0;
      cnt       <= '0;
      byte_idx  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.blk_valid) begin
            sr        <= bus.blk_data;
            tx_data_q <= in_head;
            byte_idx  <= '0;
            err       <= 1'b0;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          // A stale busy from the previous byte holds the trigger back.
          if (!bus.tx_busy) begin
            cnt   <= '0;
            state <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          cnt <= cnt + 1'b1;
          if (bus.tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (byte_idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              sr        <= sr_next;
              tx_data_q <= next_head;
              byte_idx  <= byte_idx + 1'b1;
              state     <= S_SEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_uart_byte_serializer.sv
// tb/tb_aes_uart_byte_serializer.sv - directed self-checking bench for aes_uart_byte_serializer
module tb_aes_uart_byte_serializer;

  localparam int BUSY_LEN = 6;
  localparam logic [127:0] BLK     = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] BLK_REV = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] BLK2    = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_uart_byte_serializer_if #(.NUM_BYTES(16)) bus_a ();
  aes_uart_byte_serializer_if #(.NUM_BYTES(16)) bus_b ();

  logic       done_a, err_a, done_b, err_b;
  logic [3:0] idx_a, idx_b;

  aes_uart_byte_serializer #(.NUM_BYTES(16), .MSB_FIRST(1'b1), .ACK_TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .done(done_a), .err(err_a), .byte_idx(idx_a)
  );
  aes_uart_byte_serializer #(.NUM_BYTES(16), .MSB_FIRST(1'b0), .ACK_TIMEOUT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .done(done_b), .err(err_b), .byte_idx(idx_b)
  );

  // Transmitter models: busy rises the cycle after a trigger and lasts BUSY_LEN cycles.
  logic       mbusy_a = 1'b0, mbusy_b = 1'b0;
  int         mcnt_a = 0, mcnt_b = 0;
  int         ntrig_a = 0, ntrig_b = 0, ndone_a = 0, ndone_b = 0;
  logic [7:0] log_a[$];
  logic [7:0] log_b[$];
  logic       force_a, forced_a;

  assign bus_a.tx_busy = force_a ? forced_a : mbusy_a;
  assign bus_b.tx_busy = mbusy_b;

  always @(posedge clk) begin
    if (done_a) ndone_a <= ndone_a + 1;
    if (!rst_n) begin
      mbusy_a <= 1'b0;
      mcnt_a  <= 0;
    end else if (bus_a.tx_trigger) begin
      ntrig_a <= ntrig_a + 1;
      log_a.push_back(bus_a.tx_data);
      mbusy_a <= 1'b1;
      mcnt_a  <= BUSY_LEN;
    end else if (mbusy_a) begin
      if (mcnt_a == 1) mbusy_a <= 1'b0;
      mcnt_a <= mcnt_a - 1;
    end
  end

  always @(posedge clk) begin
    if (done_b) ndone_b <= ndone_b + 1;
    if (!rst_n) begin
      mbusy_b <= 1'b0;
      mcnt_b  <= 0;
    end else if (bus_b.tx_trigger) begin
      ntrig_b <= ntrig_b + 1;
      log_b.push_back(bus_b.tx_data);
      mbusy_b <= 1'b1;
      mcnt_b  <= BUSY_LEN;
    end else if (mbusy_b) begin
      if (mcnt_b == 1) mbusy_b <= 1'b0;
      mcnt_b <= mcnt_b - 1;
    end
  end

  int n_pass = 0, n_total = 0, n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] gather_a(input int base);
    logic [127:0] v = '0;
    for (int k = 0; k < 16; k++)
      v = {v[119:0], (base + k < log_a.size()) ? log_a[base + k] : 8'hxx};
    return v;
  endfunction

  function automatic logic [127:0] gather_b(input int base);
    logic [127:0] v = '0;
    for (int k = 0; k < 16; k++)
      v = {v[119:0], (base + k < log_b.size()) ? log_b[base + k] : 8'hxx};
    return v;
  endfunction

  task automatic wait_done_a(input string tag);
    for (int i = 0; i < 3000 && !done_a; i++) @(negedge clk);
    check(tag, done_a, 1'b1);
  endtask

  task automatic send_a(input logic [127:0] d);
    bus_a.blk_data  = d;
    bus_a.blk_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.blk_valid = 1'b0;
  endtask

  initial begin
    int base, tb, db, n;
    logic leak, seen;
    rst_n = 1'b0;
    force_a = 1'b0; forced_a = 1'b0;
    bus_a.blk_valid = 1'b0; bus_a.blk_data = '0;
    bus_b.blk_valid = 1'b0; bus_b.blk_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",   bus_a.blk_ready, 1'b1);
    check("rst_trigger", bus_a.tx_trigger, 1'b0);
    check("rst_tx_data", bus_a.tx_data, 8'h00);
    check("rst_done",    done_a, 1'b0);
    check("rst_err",     err_a, 1'b0);
    check("rst_idx",     idx_a, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MSB-first block, with a second block held on blk_valid throughout
    base = log_a.size(); tb = ntrig_a; db = ndone_a;
    bus_a.blk_data = BLK; bus_a.blk_valid = 1'b1;
    @(posedge clk); #1;
    check("ready_low_after_accept", bus_a.blk_ready, 1'b0);
    bus_a.blk_data = BLK2;
    @(negedge clk);
    check("first_trigger_latency", bus_a.tx_trigger, 1'b1);
    check("first_byte", bus_a.tx_data, 8'h00);
    leak = 1'b0;
    for (int i = 0; i < 3000 && !done_a; i++) begin
      @(negedge clk);
      if (bus_a.blk_ready && !done_a) leak = 1'b1;
    end
    check("done_blk1", done_a, 1'b1);
    check("ready_low_in_flight", leak, 1'b0);
    check("trig_count_blk1", ntrig_a - tb, 16);
    check("idx_last", idx_a, 4'd15);
    check("ready_in_done_cycle", bus_a.blk_ready, 1'b1);
    @(posedge clk); #1;
    bus_a.blk_valid = 1'b0;
    check("blk2_accepted", bus_a.blk_ready, 1'b0);
    check("done_count_blk1", ndone_a - db, 1);
    check("bytes_blk1", gather_a(base), BLK);
    wait_done_a("done_blk2");
    @(negedge clk);
    check("bytes_blk2", gather_a(base + 16), BLK2);
    check("trig_count_blk2", ntrig_a - tb, 32);
    check("done_count_blk2", ndone_a - db, 2);

    // LSB-first instance
    bus_b.blk_data = BLK; bus_b.blk_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.blk_valid = 1'b0;
    for (int i = 0; i < 3000 && !done_b; i++) @(negedge clk);
    check("done_lsb", done_b, 1'b1);
    @(negedge clk);
    check("bytes_lsb", gather_b(0), BLK_REV);
    check("ready_after_done_lsb", bus_b.blk_ready, 1'b1);
    check("trig_count_lsb", ntrig_b, 16);
    check("done_count_lsb", ndone_b, 1);

    // Transmitter never acknowledges
    force_a = 1'b1; forced_a = 1'b0;
    tb = ntrig_a; db = ndone_a;
    send_a(BLK);
    @(negedge clk);
    check("timeout_trigger", bus_a.tx_trigger, 1'b1);
    n = 0;
    while (!err_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, 9);
    check("timeout_one_trigger", ntrig_a - tb, 1);
    check("timeout_ready", bus_a.blk_ready, 1'b1);
    repeat (4) @(negedge clk);
    check("err_sticky", err_a, 1'b1);
    check("timeout_no_done", ndone_a - db, 0);
    force_a = 1'b0;
    base = log_a.size();
    send_a(BLK);
    check("err_cleared", err_a, 1'b0);
    wait_done_a("done_after_err");
    @(negedge clk);
    check("bytes_after_err", gather_a(base), BLK);

    // Reset during byte 5 WAIT_DONE
    send_a(BLK2);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (idx_a == 4'd5 && bus_a.tx_busy) seen = 1'b1;
    end
    check("reached_byte5", seen, 1'b1);
    repeat (2) @(negedge clk);
    db = ndone_a;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready",   bus_a.blk_ready, 1'b1);
    check("midrst_trigger", bus_a.tx_trigger, 1'b0);
    check("midrst_tx_data", bus_a.tx_data, 8'h00);
    check("midrst_idx",     idx_a, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", ndone_a - db, 0);
    base = log_a.size(); tb = ntrig_a;
    send_a(BLK);
    wait_done_a("done_after_rst");
    @(negedge clk);
    check("bytes_after_rst", gather_a(base), BLK);
    check("trig_after_rst", ntrig_a - tb, 16);
    check("done_after_rst_once", ndone_a - db, 1);

    // Stale busy when SEND is entered
    force_a = 1'b1; forced_a = 1'b1;
    base = log_a.size(); tb = ntrig_a;
    send_a(BLK2);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus_a.tx_trigger) seen = 1'b1;
    end
    check("stale_no_trigger", seen, 1'b0);
    force_a = 1'b0;
    #1;
    check("stale_trigger_on_fall", bus_a.tx_trigger, 1'b1);
    @(negedge clk);
    check("stale_trigger_one_cycle", bus_a.tx_trigger, 1'b0);
    wait_done_a("done_stale");
    @(negedge clk);
    check("bytes_stale", gather_a(base), BLK2);
    check("trig_stale", ntrig_a - tb, 16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
